multicycle_alu_exec: RTL and testbench



---
 rtl/multicycle_alu_exec_pkg.sv | 61 ++++++
 rtl/multicycle_alu_exec_shift_add_mul.sv | 63 ++++++
 rtl/multicycle_alu_exec.sv | 137 +++++++++++++
 tb/tb_multicycle_alu_exec.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_exec_pkg.sv
// Shared definitions for the LEGv8 execute-stage ALU: ALU function codes,
// R-type opcode constants, FSM states and the ALUOp/opcode decoder.
package multicycle_alu_exec_pkg;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_OR     = 4'b0001,
        ALU_ADD    = 4'b0010,
        ALU_LSL    = 4'b0011,
        ALU_LSR    = 4'b0100,
        ALU_MUL    = 4'b0101,
        ALU_SUB    = 4'b0110,
        ALU_PASS_B = 4'b0111
    } alu_ctl_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_LSL = 11'b11010011011;
    localparam logic [10:0] OPC_LSR = 11'b11010011010;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    typedef struct packed {
        alu_ctl_e ctl;
        logic     illegal;
    } decode_t;

    // ALUOp=00 forces ADD, ALUOp=X1 forces PASS_B, only ALUOp=10 looks at the opcode.
    function automatic decode_t alu_decode(input logic [1:0] alu_op, input logic [10:0] opc);
        decode_t d;
        d.ctl     = ALU_PASS_B;
        d.illegal = 1'b0;
        if (alu_op == 2'b00) begin
            d.ctl = ALU_ADD;
        end else if (alu_op[0]) begin
            d.ctl = ALU_PASS_B;
        end else begin
            case (opc)
                OPC_ADD: d.ctl = ALU_ADD;
                OPC_SUB: d.ctl = ALU_SUB;
                OPC_AND: d.ctl = ALU_AND;
                OPC_ORR: d.ctl = ALU_OR;
                OPC_LSL: d.ctl = ALU_LSL;
                OPC_LSR: d.ctl = ALU_LSR;
                OPC_MUL: d.ctl = ALU_MUL;
                default: begin
                    d.ctl     = ALU_PASS_B;
                    d.illegal = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/multicycle_alu_exec_shift_add_mul.sv
// Iterative unsigned shift-add multiplier retiring BITS_PER_CYCLE multiplier
// bits per step; product is truncated to DATA_W bits.
module shift_add_mul #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_last,
    output logic [DATA_W-1:0] o_product
);

    localparam int ITERS = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_partial;

    // Multiplicand times the low multiplier bits, built from shifted copies
    // so no hardware multiplier is inferred.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_partial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_mplier[k]) begin
                w_partial = w_partial + (r_mcand << k);
            end
        end
    end

    // o_product is the accumulator after the current step, so the top can
    // capture the finished product on the final step's edge.
    assign o_product = r_acc + w_partial;
    assign o_last    = (r_count == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_count  <= CNT_W'(ITERS);
        end else if (i_step) begin
            r_acc    <= o_product;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_count  <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu_exec.sv
// LEGv8 execute-stage ALU: combinational decode, single-cycle datapath ops and
// a multi-cycle MUL behind a valid/ready handshake, all with registered outputs.
module multicycle_alu_exec
    import multicycle_alu_exec_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHAMT_W        = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         ALUOp,
    input  logic [10:0]        opcode,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic [3:0]         alu_ctl,
    output logic               illegal,
    output logic               stall
);

    state_e            r_state;
    state_e            w_state_nxt;
    decode_t           w_dec;
    logic [DATA_W-1:0] w_single;
    logic              w_accept;
    logic              w_mul_load;
    logic              w_mul_step;
    logic              w_mul_last;
    logic [DATA_W-1:0] w_mul_product;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    alu_ctl_e          r_alu_ctl;
    logic              r_illegal;

    assign w_dec    = alu_decode(ALUOp, opcode);
    assign in_ready = (r_state == ST_IDLE);
    assign stall    = ~in_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_single = op_b;
        case (w_dec.ctl)
            ALU_ADD:    w_single = op_a + op_b;
            ALU_SUB:    w_single = op_a - op_b;
            ALU_AND:    w_single = op_a & op_b;
            ALU_OR:     w_single = op_a | op_b;
            ALU_LSL:    w_single = op_a << shamt;
            ALU_LSR:    w_single = op_a >> shamt;
            default:    w_single = op_b;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_load  = 1'b0;
        w_mul_step  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_dec.ctl == ALU_MUL)) begin
                    w_mul_load  = 1'b1;
                    w_state_nxt = ST_MUL_RUN;
                end
            end
            ST_MUL_RUN: begin
                w_mul_step = 1'b1;
                if (w_mul_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    shift_add_mul #(
        .DATA_W         (DATA_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_mul_load),
        .i_step    (w_mul_step),
        .i_a       (op_a),
        .i_b       (op_b),
        .o_last    (w_mul_last),
        .o_product (w_mul_product)
    );

    // alu_ctl/illegal track the last accepted op; result/zero only change when
    // that op finishes, so a MUL leaves the previous result visible meanwhile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_alu_ctl   <= ALU_ADD;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_alu_ctl <= w_dec.ctl;
                r_illegal <= w_dec.illegal;
                if (w_dec.ctl != ALU_MUL) begin
                    r_result    <= w_single;
                    r_zero      <= (w_single == '0);
                    r_out_valid <= 1'b1;
                end
            end else if ((r_state == ST_MUL_RUN) && w_mul_last) begin
                r_result    <= w_mul_product;
                r_zero      <= (w_mul_product == '0);
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign alu_ctl   = r_alu_ctl;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_multicycle_alu_exec.sv
// Self-checking bench: directed corner cases plus randomized ops checked
// against a plain-arithmetic reference model; a second instance runs 4 bits/step.
module tb_multicycle_alu_exec;
    import multicycle_alu_exec_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_valid4;
    logic [1:0]    aluop;
    logic [10:0]   opcode;
    logic [DW-1:0] op_a, op_b;
    logic [5:0]    shamt;

    logic          in_ready, out_valid, zero, illegal, stall;
    logic [DW-1:0] result;
    logic [3:0]    alu_ctl;
    logic          in_ready4, out_valid4, zero4, illegal4, stall4;
    logic [DW-1:0] result4;
    logic [3:0]    alu_ctl4;

    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    multicycle_alu_exec #(.DATA_W(DW), .BITS_PER_CYCLE(1), .SHAMT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(aluop), .opcode(opcode), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid), .result(result), .zero(zero), .alu_ctl(alu_ctl),
        .illegal(illegal), .stall(stall)
    );

    multicycle_alu_exec #(.DATA_W(DW), .BITS_PER_CYCLE(4), .SHAMT_W(6)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .ALUOp(aluop), .opcode(opcode), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid4), .result(result4), .zero(zero4), .alu_ctl(alu_ctl4),
        .illegal(illegal4), .stall(stall4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: decode rules and arithmetic written directly from the ISA table.
    function automatic void model(input logic [1:0] aop, input logic [10:0] opc,
                                  input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh,
                                  output logic [63:0] res, output logic [3:0] ctl, output logic ill);
        ill = 1'b0;
        if (aop == 2'b00)      ctl = ALU_ADD;
        else if (aop[0])       ctl = ALU_PASS_B;
        else if (opc == OPC_ADD) ctl = ALU_ADD;
        else if (opc == OPC_SUB) ctl = ALU_SUB;
        else if (opc == OPC_AND) ctl = ALU_AND;
        else if (opc == OPC_ORR) ctl = ALU_OR;
        else if (opc == OPC_LSL) ctl = ALU_LSL;
        else if (opc == OPC_LSR) ctl = ALU_LSR;
        else if (opc == OPC_MUL) ctl = ALU_MUL;
        else begin
            ctl = ALU_PASS_B;
            ill = 1'b1;
        end
        if (ctl == ALU_ADD)      res = a + b;
        else if (ctl == ALU_SUB) res = a - b;
        else if (ctl == ALU_AND) res = a & b;
        else if (ctl == ALU_OR)  res = a | b;
        else if (ctl == ALU_LSL) res = a << sh;
        else if (ctl == ALU_LSR) res = a >> sh;
        else if (ctl == ALU_MUL) res = a * b;
        else                     res = b;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_ov"},    out_valid, 0);
        check({tag, "_res"},   result, 0);
        check({tag, "_zero"},  zero, 1);
        check({tag, "_rdy"},   in_ready, 1);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_ctl"},   alu_ctl, ALU_ADD);
        check({tag, "_ill"},   illegal, 0);
    endtask

    // Latency = clock edges from the accept edge to the edge raising out_valid.
    task automatic run_op(input logic [1:0] aop, input logic [10:0] opc,
                          input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh,
                          output logic [63:0] got);
        logic [63:0] e_res;
        logic [3:0]  e_ctl;
        logic        e_ill;
        int          e_lat, lat, busy;
        model(aop, opc, a, b, sh, e_res, e_ctl, e_ill);
        e_lat = (e_ctl == ALU_MUL) ? DW : 0;
        @(negedge clk);
        check("ready", in_ready, 1);
        in_valid = 1'b1; aluop = aop; opcode = opc; op_a = a; op_b = b; shamt = sh;
        @(posedge clk);
        lat  = -1;
        busy = 0;
        for (int k = 0; k < 200 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_valid = 1'b0;
                op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
                aluop = 2'($urandom); opcode = 11'($urandom);
            end
            if (!in_ready) busy++;
            if (stall !== ~in_ready) check("stall_eq", stall, ~in_ready);
            if (out_valid) lat = k;
        end
        check("latency", lat, e_lat);
        check("busy", busy, e_lat);
        check("result", result, e_res);
        check("zero", zero, (e_res == 0));
        check("ctl", alu_ctl, e_ctl);
        check("illegal", illegal, e_ill);
        got = result;
        @(negedge clk);
        check("pulse", out_valid, 0);
    endtask

    task automatic run_mul4(input logic [63:0] a, input logic [63:0] b);
        int lat, busy;
        @(negedge clk);
        in_valid4 = 1'b1; aluop = 2'b10; opcode = OPC_MUL; op_a = a; op_b = b;
        @(posedge clk);
        lat  = -1;
        busy = 0;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_valid4 = 1'b0;
                op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            end
            if (!in_ready4) busy++;
            if (out_valid4) lat = k;
        end
        check("m4_latency", lat, DW / 4);
        check("m4_busy", busy, DW / 4);
        check("m4_result", result4, a * b);
        check("m4_ctl", alu_ctl4, ALU_MUL);
        @(negedge clk);
        check("m4_pulse", out_valid4, 0);
    endtask

    initial begin
        logic [63:0] got, a, b;
        logic [10:0] opcs [7];
        int pulses, sel;
        n_checks = 0;
        n_errors = 0;
        opcs[0] = OPC_ADD; opcs[1] = OPC_SUB; opcs[2] = OPC_AND; opcs[3] = OPC_ORR;
        opcs[4] = OPC_LSL; opcs[5] = OPC_LSR; opcs[6] = OPC_MUL;
        reset_n = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0;
        aluop = '0; opcode = '0; op_a = '0; op_b = '0; shamt = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_state("rst_rel");

        run_op(2'b10, OPC_SUB, 64'd5, 64'd7, 6'd0, got);
        check("sub_lit", got, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(2'b00, OPC_SUB, 64'd0, 64'd0, 6'd0, got);
        check("add0_zero", zero, 1);
        run_op(2'b11, OPC_SUB, 64'd99, 64'h1234, 6'd0, got);
        check("passb_lit", got, 64'h1234);
        run_op(2'b10, 11'b11111111111, 64'd1, 64'hABCD, 6'd0, got);
        check("illegal_lit", illegal, 1);
        run_op(2'b10, OPC_LSL, 64'd1, 64'd0, 6'd63, got);
        check("lsl63_lit", got, 64'h8000_0000_0000_0000);
        run_op(2'b10, OPC_LSR, 64'd1, 64'd0, 6'd63, got);
        check("lsr63_lit", got, 64'd0);
        a = {$urandom, $urandom};
        run_op(2'b10, OPC_LSL, a, 64'd0, 6'd0, got);
        check("lsl0_lit", got, a);
        run_op(2'b10, OPC_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 6'd0, got);
        check("mul_lit", got, 64'hFFFF_FFFF_FFFF_FFFD);
        run_mul4(64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        run_mul4({$urandom, $urandom}, {$urandom, $urandom});

        // Back-to-back ADD then MUL with in_valid held until the MUL reports.
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; opcode = OPC_ADD; op_a = 64'd10; op_b = 64'd20;
        @(posedge clk);
        @(negedge clk);
        check("b2b_add_ov", out_valid, 1);
        check("b2b_add_res", result, 64'd30);
        opcode = OPC_MUL; op_a = 64'd1000; op_b = 64'd77;
        @(posedge clk);
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                in_valid = 1'b0;
                check("b2b_mul_res", result, 64'd77000);
            end
        end
        check("b2b_pulses", pulses, 1);

        // Reset part-way through a MUL; the partial product must never surface.
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; opcode = OPC_MUL; op_a = 64'd12345; op_b = 64'd678;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset_n = 1'b0;
        #2 check_reset_state("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'b10, OPC_ADD, 64'd2, 64'd2, 6'd0, got);
        check("post_rst_add", got, 64'd4);
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("no_stale", pulses, 0);

        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? 64'(($urandom_range(0, 3))) : {$urandom, $urandom};
            if (sel < 7)       run_op(2'b10, opcs[sel], a, b, 6'($urandom), got);
            else if (sel == 7) run_op(2'b00, 11'($urandom), a, b, 6'($urandom), got);
            else if (sel == 8) run_op({1'($urandom), 1'b1}, 11'($urandom), a, b, 6'($urandom), got);
            else               run_op(2'b10, 11'($urandom), a, b, 6'($urandom), got);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
